// File: rtl/uart_tx_arbiter_if.sv
// Requester and tx-engine signals of the UART transmit arbiter; master = arbiter side.
// Slices are per requester: req_data[8i+7:8i], req_cfg[3i+2:3i] = {eight,pen,ohel}.
interface uart_tx_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int GW    = 2,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]       req;
    logic [8*NREQ-1:0]     req_data;
    logic [3*NREQ-1:0]     req_cfg;
    logic [NREQ-1:0]       ack;
    logic [GW-1:0]         grant;
    logic                  busy;
    logic                  txrdy;
    logic                  load;
    logic [7:0]            out_port;
    logic                  eight;
    logic                  pen;
    logic                  ohel;
    logic [CNT_W*NREQ-1:0] sent_count;

    modport master (
        input  req, req_data, req_cfg, txrdy,
        output ack, grant, busy, load, out_port, eight, pen, ohel, sent_count
    );

    modport slave (
        output req, req_data, req_cfg, txrdy,
        input  ack, grant, busy, load, out_port, eight, pen, ohel, sent_count
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART tx engine among NREQ requesters; per-requester counters under UART_TX_ARBITER_STATS_EN.
// Latency: load/ack one cycle after a request is seen in IDLE with txrdy high; all outputs registered.
// Backpressure: no grant while txrdy is low or a frame is in flight; next load no sooner than 2 cycles after txrdy rises.
module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int GW    = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_arbiter_if.master       bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            load_q, load_d;
    logic            busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      cfg_q, cfg_d;

    logic            found;
    logic [GW-1:0]   win;
    logic [GW-1:0]   cand;
    logic [7:0]      sel_data;
    logic [2:0]      sel_cfg;

    // Search starts just after the last winner so every holder gets a turn within NREQ-1 frames.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_cfg  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
                sel_data = bus.req_data[8*i +: 8];
                sel_cfg  = bus.req_cfg[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = '0;
        load_d  = 1'b0;
        busy_d  = busy_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        case (state_q)
            IDLE: begin
                if (bus.txrdy && found) begin
                    load_d  = 1'b1;
                    ack_d   = NREQ'(1) << win;
                    data_d  = sel_data;
                    cfg_d   = sel_cfg;
                    grant_d = win;
                    ptr_d   = win;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD:      state_d = WAIT_BUSY;
            WAIT_BUSY: if (!bus.txrdy) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.txrdy) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NREQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
            cfg_q   <= 3'b100;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.grant    = grant_q;
    assign bus.load     = load_q;
    assign bus.busy     = busy_q;
    assign bus.out_port = data_q;
    assign bus.eight    = cfg_q[2];
    assign bus.pen      = cfg_q[1];
    assign bus.ohel     = cfg_q[0];

`ifdef UART_TX_ARBITER_STATS_EN
    logic [CNT_W*NREQ-1:0] cnt_q, cnt_d;

    // Counts follow the registered ack, so a slice moves one cycle after its ack pulse.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_q[i] && (cnt_q[CNT_W*i +: CNT_W] != {CNT_W{1'b1}})) begin
                cnt_d[CNT_W*i +: CNT_W] = cnt_q[CNT_W*i +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.sent_count = cnt_q;
`else
    assign bus.sent_count = '0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset values, round-robin order, txrdy gating, withdrawal, cfg hold, mid-frame reset.
// The tx engine is played by the main sequence: txrdy drops the cycle after load and returns after a set frame length.
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int GW    = 2;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .GW(GW), .CNT_W(CNT_W)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .GW(GW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] data, input logic [2:0] cfg);
        bus.req_data[8*i +: 8] = data;
        bus.req_cfg[3*i +: 3]  = cfg;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_load"},  32'(bus.load), 32'd0);
        check({tag, "_ack"},   32'(bus.ack), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_out"},   32'(bus.out_port), 32'h00);
        check({tag, "_cfg"},   32'({bus.eight, bus.pen, bus.ohel}), 32'b100);
        check({tag, "_cnt"},   32'(bus.sent_count[31:0]), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_load(input string tag, input int max);
        int n = 0;
        while (bus.load !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check({tag, "_load"}, 32'(bus.load), 32'd1);
    endtask

    // Called right after the edge that raised load; returns right after the edge that dropped busy.
    task automatic finish_frame(input int len);
        step();
        bus.txrdy = 1'b0;
        repeat (len) step();
        bus.txrdy = 1'b1;
        step();
    endtask

    task automatic grant_chk(input string tag, input int idx, input logic [7:0] data);
        wait_load(tag, 20);
        check({tag, "_grant"}, 32'(bus.grant), 32'(idx));
        check({tag, "_ack"},   32'(bus.ack), 32'(1) << idx);
        check({tag, "_out"},   32'(bus.out_port), 32'(data));
    endtask

    initial begin
        int seq2 [5];
        int seq3 [3];
        logic seen;
        seq2 = '{0, 1, 2, 3, 0};
        seq3 = '{1, 3, 1};

        bus.req      = '0;
        bus.req_data = '0;
        bus.req_cfg  = '0;
        bus.txrdy    = 1'b1;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Single request: one-cycle latency and long frame.
        set_req(0, 8'hA5, 3'b110);
        bus.req = 4'b0001;
        step();
        check("t1_load",  32'(bus.load), 32'd1);
        check("t1_ack",   32'(bus.ack), 32'b0001);
        check("t1_out",   32'(bus.out_port), 32'hA5);
        check("t1_cfg",   32'({bus.eight, bus.pen, bus.ohel}), 32'b110);
        check("t1_busy",  32'(bus.busy), 32'd1);
        bus.req = 4'b0000;
        step();
        bus.txrdy = 1'b0;
        check("t1_load_off", 32'(bus.load), 32'd0);
        check("t1_ack_off",  32'(bus.ack), 32'd0);
        repeat (110) step();
        bus.txrdy = 1'b1;
        check("t1_busy_hold", 32'(bus.busy), 32'd1);
        step();
        check("t1_busy_fall", 32'(bus.busy), 32'd0);

        // All four holding: strict rotation starting at 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), 3'b100);
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            grant_chk($sformatf("t2_f%0d", f), seq2[f], 8'h10 + 8'(seq2[f]));
            check($sformatf("t2_f%0d_onehot", f), 32'($countones(bus.ack)), 32'd1);
            finish_frame(3);
        end

        // Pointer wrap with two requesters.
        bus.req = 4'b1010;
        for (int f = 0; f < 3; f++) begin
            grant_chk($sformatf("t3_f%0d", f), seq3[f], 8'h10 + 8'(seq3[f]));
            finish_frame(3);
        end
        bus.req = 4'b0000;

        // txrdy low blocks any grant.
        bus.txrdy = 1'b0;
        bus.req   = 4'b0100;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | bus.load | (|bus.ack);
        end
        check("t4_no_grant", 32'(seen), 32'd0);
        bus.txrdy = 1'b1;
        step();
        check("t4_load", 32'(bus.load), 32'd1);
        check("t4_grant", 32'(bus.grant), 32'd2);
        bus.req = 4'b0000;
        finish_frame(3);

        // Requester 2 withdraws while 1 is being served.
        set_req(1, 8'h21, 3'b000);
        bus.req = 4'b0110;
        grant_chk("t5a", 1, 8'h21);
        bus.req = 4'b0000;
        seen = 1'b0;
        step();
        bus.txrdy = 1'b0;
        repeat (3) step();
        bus.txrdy = 1'b1;
        repeat (5) begin
            step();
            seen = seen | bus.ack[2] | bus.load;
        end
        check("t5a_withdraw", 32'(seen), 32'd0);

        // cfg change after ack does not reach the engine.
        set_req(2, 8'h5C, 3'b101);
        bus.req = 4'b0100;
        grant_chk("t5b", 2, 8'h5C);
        check("t5b_cfg", 32'({bus.eight, bus.pen, bus.ohel}), 32'b101);
        set_req(2, 8'hFF, 3'b010);
        bus.req = 4'b0000;
        step();
        bus.txrdy = 1'b0;
        step();
        step();
        check("t5b_cfg_hold", 32'({bus.eight, bus.pen, bus.ohel}), 32'b101);
        check("t5b_out_hold", 32'(bus.out_port), 32'h5C);
        bus.txrdy = 1'b1;
        step();
        step();

        // Single requester is granted every frame; counters where present.
        do_reset();
        set_req(1, 8'h31, 3'b100);
        bus.req = 4'b0010;
        for (int f = 0; f < 5; f++) begin
            grant_chk($sformatf("t6_f%0d", f), 1, 8'h31);
            finish_frame(2);
        end
        bus.req = 4'b0000;
        step();
`ifdef UART_TX_ARBITER_STATS_EN
        check("t6_cnt1", 32'(bus.sent_count[31:16]), 32'd5);
`else
        check("t6_cnt1", 32'(bus.sent_count[31:16]), 32'd0);
`endif
        check("t6_cnt0", 32'(bus.sent_count[15:0]), 32'd0);

        // Reset in WAIT_DONE.
        set_req(3, 8'hE7, 3'b011);
        bus.req = 4'b1000;
        grant_chk("t7", 3, 8'hE7);
        bus.req = 4'b0000;
        step();
        bus.txrdy = 1'b0;
        step();
        step();
        check("t7_busy", 32'(bus.busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("t7_rst");
        step();
        bus.txrdy = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 8'h42, 3'b100);
        bus.req = 4'b1001;
        step();
        check("t7_post_load",  32'(bus.load), 32'd1);
        check("t7_post_grant", 32'(bus.grant), 32'd0);
        check("t7_post_out",   32'(bus.out_port), 32'h42);
        bus.req = 4'b0000;
        finish_frame(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmit engine among NREQ byte requesters.
- Sits between the requesters and the tx engine. Drives the engine's load, out_port, eight, pen and ohel; watches its txrdy.
- Owns each requester's frame configuration for the whole frame, so requesters with different framing can share the line.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- GW, 2, grant index width; must equal ceil(log2(NREQ)).
- CNT_W, 16, width of each per-requester sent counter (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  request per requester; held high until ack.
- req_data  in  8*NREQ  byte per requester; slice i = [8i+7:8i].
- req_cfg  in  3*NREQ  {eight,pen,ohel} per requester; slice i = [3i+2:3i].
- ack  out  NREQ  one-cycle pulse: byte of requester i handed to engine.
- grant  out  GW  index of last/current granted requester.
- busy  out  1  high from load until engine txrdy returns.
- txrdy  in  1  engine ready; high out of engine reset.
- load  out  1  one-cycle load strobe to engine.
- out_port  out  8  byte to engine.
- eight, pen, ohel  out  1 each  frame configuration to engine.
- sent_count  out  CNT_W*NREQ  per-requester frames sent (optional feature).

Behaviour:
- All outputs are registered. Reset values:
  - load=0, ack=0, busy=0, grant=0, out_port=8'h00.
  - eight=1, pen=0, ohel=0.
  - sent_count=0.
  - RR pointer=NREQ-1, so requester 0 wins first. State=IDLE.
- IDLE:
  - Condition: txrdy=1 and |req.
  - Winner: first asserted req searching from pointer+1 upward, wrapping modulo NREQ.
  - At the next edge: load=1, ack[winner]=1; out_port, eight, pen, ohel take the winner's slice; grant=winner; pointer=winner; busy=1; state→LOAD.
  - Latency from req seen to load: 1 cycle.
- IDLE with txrdy=0: no grant, regardless of req.
- LOAD: lasts 1 cycle. Next edge: load=0, ack=0, state→WAIT_BUSY.
- WAIT_BUSY: stay until txrdy=0, then →WAIT_DONE. The engine drops txrdy the cycle after load.
- WAIT_DONE: stay until txrdy=1. Next edge: busy=0, state→IDLE.
  - No new load in the cycle txrdy is seen rising. Minimum back-to-back gap is 2 cycles from txrdy rise to the next load.
- Output stability:
  - out_port, eight, pen, ohel hold from the grant edge until the next grant. The engine decodes parity from live cfg.
  - grant likewise holds until the next grant.
- Requester rules:
  - A req dropped before its ack withdraws the request; no ack.
  - Data and cfg are sampled only at the grant edge, so changes before then are harmless.
  - After ack the requester may present a new byte; re-raising req next cycle is legal. That request waits its RR turn.
- Simultaneous requests: exactly one ack per frame. A requester holding req continuously waits at most NREQ-1 frames.
- Single requester only: it is granted every frame.
- Reset asserted mid-frame:
  - Immediate return to reset values. load/ack are never left high.
  - Any frame in flight is abandoned; the engine is reset by the same signal.
- ack is never asserted for more than one requester, and never outside LOAD.

Optional Feature:
- Macro: UART_TX_ARBITER_STATS_EN.
- Defined:
  - sent_count slice i increments by 1 on each ack[i].
  - Saturates at all-ones; cleared only by reset.
- Undefined:
  - No counter registers.
  - sent_count is tied to 0; the port still exists so the interface does not change.

Test Plan:
- Reset, txrdy=1, req=4'b0001, data0=8'hA5, cfg0=3'b110: one cycle after req, see load=1, ack=4'b0001, out_port=8'hA5, eight=1, pen=1, ohel=0. Model txrdy low for 110 cycles then high: busy falls exactly 1 cycle after txrdy rises.
- req=4'b1111 held continuously with distinct bytes 8'h10..8'h13: grant order 0,1,2,3,0; exactly one ack per frame.
- req=4'b1010 after a grant to 1: next grant 3, then 1. Pointer wraps correctly.
- txrdy held 0 with req=4'b0100: no load, no ack. Raise txrdy: load 1 cycle later.
- Requester 2 drops req before its turn while req1 is granted: no ack[2]. Separately, change cfg2 after ack mid-frame: eight, pen, ohel unchanged.
- Assert reset during WAIT_DONE: all outputs return to reset values. With UART_TX_ARBITER_STATS_EN, 5 frames from requester 1 give sent_count[31:16]=5; reset clears it to 0.
